// File: rtl/spi_sampled_slave.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_sampled_slave
//
// SPI mode-0 slave engine that lives entirely in the core clock domain. The
// sclk, mosi and ss pins are oversampled through NSYNC-deep synchronizers.
// Edges of the synchronized sclk drive a byte-oriented register protocol:
//
//   byte 0      : command  {rw, inc, addr[5:0]}  (rw = 1 -> read)
//   byte 1..n   : data bytes (written to, or read from, the register file)
//
// Writes produce a one-cycle reg_wr strobe per data byte. Reads produce a
// one-cycle reg_rd strobe at command completion and at every data byte
// completion. reg_rdata is captured into the transmit shifter in the strobe
// cycle and shifted out on miso, one bit per sclk fall. The read at the last
// byte completion is a prefetch and happens even if the frame then ends.
//
// Ports
//   clk        in   core clock, all logic on the rising edge
//   nreset     in   asynchronous active-low reset
//   hw_en      in   block enable; low aborts any frame and holds IDLE
//   sclk       in   SPI clock from the master (CPOL=0, CPHA=0)
//   mosi       in   SPI data in, MSB first
//   ss         in   slave select, active low
//   miso       out  SPI data out, registered
//   active     out  high while a transaction is open
//   reg_wr     out  one-cycle register write strobe
//   reg_rd     out  one-cycle register read strobe
//   reg_addr   out  register address [5:0]
//   reg_wdata  out  write data [7:0], valid with reg_wr
//   reg_rdata  in   read data [7:0], combinational from reg_addr
//
// sclk high and low times must each be at least NSYNC+3 clk cycles.
// -----------------------------------------------------------------------------
module spi_sampled_slave #(
  parameter int NSYNC = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       hw_en,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       active,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [5:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and sclk edge detection
  // ---------------------------------------------------------------------------
  logic [NSYNC-1:0] r_sclk_sync;
  logic [NSYNC-1:0] r_mosi_sync;
  logic [NSYNC-1:0] r_ss_sync;
  logic             r_sclk_d;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_ss_s;
  logic w_rise;
  logic w_fall;

  // The ss synchronizer resets to 0 rather than to the idle-high level: a
  // reset released in the middle of a frame must not look like a fresh ss
  // falling edge. A real frame start needs ss to be seen high first
  // (r_ss_armed below).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop in the chain sample
      // the pre-edge value, so the synchronizer really is NSYNC stages deep.
      r_sclk_sync <= {r_sclk_sync[NSYNC-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[NSYNC-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[NSYNC-2:0], ss};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[NSYNC-1];
  assign w_mosi_s = r_mosi_sync[NSYNC-1];
  assign w_ss_s   = r_ss_sync[NSYNC-1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_fall   = ~w_sclk_s & r_sclk_d;

  // ---------------------------------------------------------------------------
  // Frame-level state
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_next_state;
  logic        r_ss_armed;     // ss has been seen high since the last frame
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_shift;     // bits already received in the current byte
  logic [7:0]  r_tx_shift;
  logic        r_rw;
  logic        r_inc;
  logic        r_miso;
  logic        r_reg_wr;
  logic        r_reg_rd;
  logic [5:0]  r_reg_addr;
  logic [7:0]  r_reg_wdata;

  logic        w_abort;
  logic [7:0]  w_rx_byte;
  logic        w_byte_done;
  logic        w_cmd_done;
  logic        w_data_done;
  logic        w_wr_set;
  logic        w_rd_set;
  logic        w_miso_shift;

  assign w_abort   = w_ss_s | ~hw_en;
  assign w_rx_byte = {r_rx_shift, w_mosi_s};

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. An abort beats a byte completion in the same cycle.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of
    // inferred latches even when a branch does not assign.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (!w_abort && r_ss_armed) w_next_state = ST_CMD;
      ST_CMD: begin
        if (w_abort)          w_next_state = ST_IDLE;
        else if (w_byte_done) w_next_state = ST_DATA;
      end
      ST_DATA: if (w_abort) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    w_byte_done  = w_rise && (r_bit_cnt == 3'd7);
    w_cmd_done   = 1'b0;
    w_data_done  = 1'b0;
    w_miso_shift = 1'b0;
    if (!w_abort) begin
      w_cmd_done   = (r_state == ST_CMD) && w_byte_done;
      w_data_done  = (r_state == ST_DATA) && w_byte_done;
      w_miso_shift = (r_state == ST_DATA) && r_rw && w_fall;
    end
    w_wr_set = w_data_done && !r_rw;
    // A read command fetches its first byte as soon as the command completes.
    w_rd_set = (w_cmd_done && w_rx_byte[7]) || (w_data_done && r_rw);
    // Derived from the next state so that active follows the synchronized ss
    // with exactly NSYNC cycles of delay in both directions.
    active   = (w_next_state != ST_IDLE);
  end

  // ss arming: a frame may only open after ss has been seen high. This keeps a
  // frame that was cut by reset or hw_en from being resumed half way through.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ss_armed <= 1'b0;
    end else if (w_ss_s) begin
      r_ss_armed <= 1'b1;
    end else if (r_state == ST_CMD) begin
      r_ss_armed <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift datapath: receive shifter, bit counter, transmit shifter, miso
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 8'd0;
      r_miso     <= 1'b0;
    end else if (r_state == ST_IDLE || w_abort) begin
      // Any partial byte is dropped and miso returns low.
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 8'd0;
      r_miso     <= 1'b0;
    end else begin
      if (w_rise) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      if (w_miso_shift) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      // The load happens in the strobe cycle right after a rise; the sclk
      // timing limits keep a fall from landing in the same cycle.
      if (r_reg_rd) begin
        r_tx_shift <= reg_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register-file strobes, address and command fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_reg_addr  <= 6'd0;
      r_reg_wdata <= 8'd0;
      r_rw        <= 1'b0;
      r_inc       <= 1'b0;
    end else begin
      r_reg_wr <= w_wr_set;
      r_reg_rd <= w_rd_set;
      if (w_cmd_done) begin
        r_rw       <= w_rx_byte[7];
        r_inc      <= w_rx_byte[6];
        r_reg_addr <= w_rx_byte[5:0];
      end
      if (w_wr_set) begin
        r_reg_wdata <= w_rx_byte;
      end
      // Post-increment after each access; 6-bit arithmetic wraps 63 -> 0.
      if ((r_reg_wr || r_reg_rd) && r_inc) begin
        r_reg_addr <= r_reg_addr + 6'd1;
      end
    end
  end

  assign miso      = r_miso;
  assign reg_wr    = r_reg_wr;
  assign reg_rd    = r_reg_rd;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;

endmodule

// File: doc/spi_sampled_slave.md
# spi_sampled_slave

Clock-domain-sampled SPI slave engine. It is the far end of the SPI master link: it receives s_sclk/s_mosi/s_ss from an external master and decodes a byte-oriented register protocol. It drives single-cycle register read/write strobes into a core-side register file and returns read data on miso. It sits beside the SPI master in the SPI top, on the core clock, with no logic clocked by sclk.

## Interface
- NSYNC, 2: synchronizer depth for sclk/mosi/ss (≥2).
- clk  in  1  core clock; all logic on rising edge.
- nreset  in  1  asynchronous active-low reset.
- hw_en  in  1  block enable; low forces IDLE, same as ss high.
- sclk  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- mosi  in  1  SPI data in, MSB first.
- ss  in  1  slave select, active low.
- miso  out  1  SPI data out, registered.
- active  out  1  high while a transaction is open (state ≠ IDLE).
- reg_wr  out  1  one-cycle register write strobe.
- reg_rd  out  1  one-cycle register read strobe; reg_rdata is sampled in the same cycle.
- reg_addr  out  6  register address.
- reg_wdata  out  8  write data, valid with reg_wr.
- reg_rdata  in  8  read data from the register file, combinational from reg_addr.

## Operation
- Protocol:
  - The first byte after ss falls is the command: bit7 = read(1)/write(0), bit6 = auto-increment, bits5:0 = start address.
  - Every following byte is a data byte.
- Sampling:
  - sclk, mosi and ss each pass through an NSYNC-flop synchronizer.
  - One extra flop on synchronized sclk provides rise/fall detection.
  - E denotes the clk cycle in which a synchronized sclk rise is detected.
- Receive: at each E, shift synchronized mosi into rx_shift and increment a 3-bit bit counter. At the 8th E the byte is complete.
- States:
  - IDLE: enter when ss = 1 or hw_en = 0. Go to CMD when ss = 0 and hw_en = 1.
  - CMD: on byte completion, latch rw, inc and addr, then go to DATA.
  - DATA: stay until ss rises or hw_en drops.
- Write (rw = 0): on each DATA byte completion, reg_wr = 1 for one cycle with the current reg_addr and reg_wdata = received byte. The cycle after, reg_addr increments if inc = 1.
- Read (rw = 1):
  - At CMD completion and at every DATA byte completion, reg_rd = 1 for one cycle with the current reg_addr.
  - In that cycle, tx_shift is loaded from reg_rdata, then reg_addr increments if inc = 1.
  - The read at the last byte completion is a prefetch and occurs even if the master then ends the frame.
- Address increment wraps 63 → 0.
- miso:
  - On each detected sclk fall while in DATA/read, miso is set to tx_shift[7] and tx_shift shifts left.
  - miso is 0 in IDLE, CMD and write transactions.
- Abort: ss rise or hw_en low in any state returns to IDLE. The bit counter is cleared, any partial byte is discarded with no strobe, and miso is 0.
- Priority: if an ss deassert and a byte completion are detected in the same cycle, the abort wins and no strobe is issued.
- Reset values: miso = 0, active = 0, reg_wr = 0, reg_rd = 0, reg_addr = 0, reg_wdata = 0, state = IDLE, counters = 0.

## Timing
- Pin to E latency is NSYNC+1 clk cycles.
- reg_wr and reg_rd are high in cycle E+1 only (8th E of a byte); reg_rdata is captured at the end of E+1.
- miso changes NSYNC+2 clk cycles after the sclk pin falls.
- sclk high time and low time must each be ≥ NSYNC+3 clk cycles (≥5 clk at default). Faster sclk is unsupported.
- ss setup: at least NSYNC+1 clk cycles from ss falling to the first sclk rise.
- active rises NSYNC cycles after ss falls and falls NSYNC cycles after ss rises.
- An nreset assertion mid-frame forces all outputs to reset values asynchronously. After release the block waits in IDLE until an ss falling edge; it never resumes a frame.

## Test plan
- Write with auto-increment: cmd 0x45, data 0xA5, 0x3C → exactly two reg_wr strobes: (addr 5, 0xA5) then (addr 6, 0x3C). miso stays 0.
- Read with wrap: register model reg[a] = a^0x55, cmd 0xFF, two data bytes → miso carries 0x6A then 0x55. reg_rd strobes at addr 63, 0, 1, the last being the prefetch.
- No auto-increment: cmd 0x0A, data 0x11, 0x22, 0x33 → three reg_wr strobes, all at addr 10, data 0x11/0x22/0x33.
- Abort: ss rises after 5 bits of the second data byte → only the first byte is written. active drops NSYNC cycles after ss rises. A following cmd 0x00 + 0x77 frame writes addr 0 = 0x77.
- hw_en dropped mid-read → state IDLE, miso = 0, no further strobes. Re-enable plus a new frame works normally.
- nreset pulsed during DATA → all outputs 0 immediately. The remaining sclk edges before ss rises produce no strobes.
- Timing corner: sclk half-period = NSYNC+3 clk exactly, random data over 64 frames → scoreboard matches with zero mismatches.
